// File: rtl/ast_mux.sv
// rtl/ast_mux.sv - Avalon-ST packet multiplexer: round-robin gather of RX_DIR sink streams into one registered source.
module ast_mux #(
  parameter int DATA_WIDTH    = 64,
  parameter int CHANNEL_WIDTH = 8,
  parameter int EMPTY_WIDTH   = $clog2(DATA_WIDTH/8),
  parameter int RX_DIR        = 4,
  parameter int DIR_SEL_WIDTH = (RX_DIR == 1) ? 1 : $clog2(RX_DIR)
) (
  input  logic                                   clk_i,
  input  logic                                   arst_i,
  input  logic [RX_DIR-1:0][DATA_WIDTH-1:0]      ast_data_i,
  input  logic [RX_DIR-1:0]                      ast_startofpacket_i,
  input  logic [RX_DIR-1:0]                      ast_endofpacket_i,
  input  logic [RX_DIR-1:0]                      ast_valid_i,
  input  logic [RX_DIR-1:0][EMPTY_WIDTH-1:0]     ast_empty_i,
  input  logic [RX_DIR-1:0][CHANNEL_WIDTH-1:0]   ast_channel_i,
  output logic [RX_DIR-1:0]                      ast_ready_o,
  output logic [DATA_WIDTH-1:0]                  ast_data_o,
  output logic                                   ast_startofpacket_o,
  output logic                                   ast_endofpacket_o,
  output logic                                   ast_valid_o,
  output logic [EMPTY_WIDTH-1:0]                 ast_empty_o,
  output logic [CHANNEL_WIDTH-1:0]               ast_channel_o,
  output logic [DIR_SEL_WIDTH-1:0]               ast_dir_o,
  input  logic                                   ast_ready_i
);

  typedef enum logic {IDLE, LOCK} state_t;

  localparam logic [DIR_SEL_WIDTH-1:0] LAST_DIR = DIR_SEL_WIDTH'(RX_DIR - 1);

  state_t                   state_q;
  state_t                   state_d;
  logic [DIR_SEL_WIDTH-1:0] ptr_q;
  logic [DIR_SEL_WIDTH-1:0] sel_q;
  logic [DIR_SEL_WIDTH-1:0] grant;
  logic [DIR_SEL_WIDTH-1:0] ptr_next;
  logic                     found;
  logic                     accept;
  logic                     out_free;

  function automatic logic [DIR_SEL_WIDTH-1:0] wrap_add(
    input logic [DIR_SEL_WIDTH-1:0] base,
    input int                       k
  );
    int s;
    s = int'(base) + k;
    if (s >= RX_DIR) s = s - RX_DIR;
    return DIR_SEL_WIDTH'(s);
  endfunction

  // Cyclic search for the first valid input at or after the round-robin pointer.
  always_comb begin
    grant = ptr_q;
    found = 1'b0;
    for (int k = 0; k < RX_DIR; k++) begin
      if (!found && ast_valid_i[wrap_add(ptr_q, k)]) begin
        grant = wrap_add(ptr_q, k);
        found = 1'b1;
      end
    end
  end

  assign ptr_next = (sel_q == LAST_DIR) ? '0 : sel_q + DIR_SEL_WIDTH'(1);
  assign out_free = !ast_valid_o || ast_ready_i;

  always_comb begin
    state_d     = state_q;
    ast_ready_o = '0;
    accept      = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) state_d = LOCK;
      end
      LOCK: begin
        ast_ready_o[sel_q] = out_free;
        accept             = ast_valid_i[sel_q] && out_free;
        if (accept && ast_endofpacket_i[sel_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q             <= IDLE;
      ptr_q               <= '0;
      sel_q               <= '0;
      ast_data_o          <= '0;
      ast_startofpacket_o <= 1'b0;
      ast_endofpacket_o   <= 1'b0;
      ast_valid_o         <= 1'b0;
      ast_empty_o         <= '0;
      ast_channel_o       <= '0;
      ast_dir_o           <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && found) sel_q <= grant;
      if (accept && ast_endofpacket_i[sel_q]) ptr_q <= ptr_next;
      // A new beat overwrites the register; otherwise a drained beat clears valid.
      if (accept) begin
        ast_data_o          <= ast_data_i[sel_q];
        ast_startofpacket_o <= ast_startofpacket_i[sel_q];
        ast_endofpacket_o   <= ast_endofpacket_i[sel_q];
        ast_empty_o         <= ast_empty_i[sel_q];
        ast_channel_o       <= ast_channel_i[sel_q];
        ast_dir_o           <= sel_q;
        ast_valid_o         <= 1'b1;
      end else if (ast_valid_o && ast_ready_i) begin
        ast_valid_o <= 1'b0;
      end
    end
  end

endmodule
